// File: rtl/vx_mem_responder.sv
// Word-addressed scratch memory that answers tagged read requests in order after LATENCY cycles.
// Optional perf counters are enabled by defining MEM_RESPONDER_PERF_EN.
module vx_mem_responder #(
    parameter int unsigned WORD_SIZE = 4,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_DEPTH = 4,
`ifdef MEM_RESPONDER_PERF_EN
    parameter int unsigned PERF_CTR_BITS = 32,
`endif
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [WORD_SIZE-1:0]   req_byteen,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [8*WORD_SIZE-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [8*WORD_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
`ifdef MEM_RESPONDER_PERF_EN
    output logic [PERF_CTR_BITS-1:0] perf_reads,
    output logic [PERF_CTR_BITS-1:0] perf_writes,
    output logic [PERF_CTR_BITS-1:0] perf_stalls,
`endif
    input  logic                   rsp_ready
);

    localparam int unsigned DW   = 8 * WORD_SIZE;
    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic            accept;
    logic            rd_acc;
    logic            wr_acc;
    logic            pop;
    logic            ready_en_q;
    logic [CntW-1:0] outstanding_q;
    logic [CntW-1:0] outstanding_d;
    logic [DW-1:0]   rd_data;

    logic                 push_valid;
    logic [DW-1:0]        push_data;
    logic [TAG_WIDTH-1:0] push_tag;

    logic [DW-1:0]        fifo_data [RSP_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag  [RSP_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      fifo_cnt_q;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic [DW-1:0] mem [DEPTH];

    // Credits cover both the read pipeline and the FIFO, so a granted read always has a slot.
    assign req_ready = ready_en_q && (outstanding_q < CntW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_rw;
    assign wr_acc    = accept && req_rw;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({rd_acc, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Store: byte-masked writes, asynchronous read sampled at accept time.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < WORD_SIZE; i++) begin
                if (req_byteen[i]) begin
                    mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[req_addr];

    // Accept cycle is the first latency cycle, so LATENCY-1 register stages precede the FIFO.
    if (LATENCY <= 1) begin : g_no_pipe
        assign push_valid = rd_acc;
        assign push_data  = rd_data;
        assign push_tag   = req_tag;
    end else begin : g_pipe
        localparam int unsigned PipeN = LATENCY - 1;

        logic [PipeN-1:0]     pipe_valid_q;
        logic [DW-1:0]        pipe_data_q [PipeN];
        logic [TAG_WIDTH-1:0] pipe_tag_q  [PipeN];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pipe_valid_q <= '0;
                for (int unsigned i = 0; i < PipeN; i++) begin
                    pipe_data_q[i] <= '0;
                    pipe_tag_q[i]  <= '0;
                end
            end else begin
                pipe_valid_q[0] <= rd_acc;
                pipe_data_q[0]  <= rd_data;
                pipe_tag_q[0]   <= req_tag;
                for (int unsigned i = 1; i < PipeN; i++) begin
                    pipe_valid_q[i] <= pipe_valid_q[i-1];
                    pipe_data_q[i]  <= pipe_data_q[i-1];
                    pipe_tag_q[i]   <= pipe_tag_q[i-1];
                end
            end
        end

        assign push_valid = pipe_valid_q[PipeN-1];
        assign push_data  = pipe_data_q[PipeN-1];
        assign push_tag   = pipe_tag_q[PipeN-1];
    end

    // Response FIFO, first-word-fall-through.
    assign fifo_full  = (fifo_cnt_q == CntW'(RSP_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_data[wr_ptr_q] <= push_data;
            fifo_tag[wr_ptr_q]  <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push_valid, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Outputs are forced to zero while empty so stale storage never leaks out.
    always_comb begin
        rsp_valid = !fifo_empty;
        rsp_data  = '0;
        rsp_tag   = '0;
        if (!fifo_empty) begin
            rsp_data = fifo_data[rd_ptr_q];
            rsp_tag  = fifo_tag[rd_ptr_q];
        end
    end

`ifdef MEM_RESPONDER_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (rd_acc) begin
                perf_reads <= perf_reads + 1'b1;
            end
            if (wr_acc) begin
                perf_writes <= perf_writes + 1'b1;
            end
            if (req_valid && !req_ready) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    push_into_full : assert property (@(posedge clk) disable iff (!reset)
        !(push_valid && fifo_full && !pop))
        else $fatal(1, "vx_mem_responder: response FIFO overflow");
`endif

endmodule
